loteria_entrada: RTL and testbench
==================================

Name: loteria_entrada

Overview:
Input-conditioning stage that sits directly upstream of the lottery game FSM. It turns raw board switches and push buttons into clean, single-cycle `insert`/`finish` strobes with a stable 4-bit digit. Work done here:
- synchronizes and debounces the button and switch inputs;
- rejects non-decimal digits;
- enforces the 5-digit entry sequence, so the game FSM never sees a malformed sequence.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a button level change is accepted (4 for simulation, raised for board builds).
- NUM_DIGITS, 5: digits per ticket.
- MAX_DIGIT, 9: largest legal digit value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; clock clk
- sw_num  input  4  raw digit switches, asynchronous
- btn_insert  input  1  raw insert button, active-high after board inversion, asynchronous, bouncy
- btn_finish  input  1  raw finish button, same electrical rules
- num  output  4  last accepted digit, held stable between accepts
- insert  output  1  one-cycle strobe, a digit was accepted
- finish  output  1  one-cycle strobe, ticket complete and finished
- digit_count  output  3  digits accepted in the current ticket, 0..NUM_DIGITS
- full  output  1  high while digit_count == NUM_DIGITS
- err  output  1  sticky error flag: invalid digit or over-entry

Behaviour:
- Synchronizers:
  - two-flop synchronizer on each of sw_num[3:0], btn_insert and btn_finish;
  - all logic below uses the synchronized values only.
- Debounce (per button):
  - counter of width clog2(DEBOUNCE_CYCLES+1);
  - counter increments while the synced level differs from the debounced level, and clears when they match;
  - on reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press events:
  - an event is a 0->1 transition of the debounced level, detected against a one-cycle-delayed copy;
  - release (1->0) is never an event;
  - glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Latency:
  - raw button first sampled high at edge k and held → strobe registered high at edge k+DEBOUNCE_CYCLES+2, low at the next edge;
  - exactly one cycle wide per press, however long the button is held.
- num capture:
  - num is loaded from synced sw_num in the same cycle insert is registered;
  - the switches must be stable ≥2 cycles before that edge.
- FSM states:
  - COLLECT:
    - insert event with synced sw_num ≤ MAX_DIGIT: load num, pulse insert, increment digit_count, clear err;
    - if the new count == NUM_DIGITS, go to FULL;
    - insert event with sw_num > MAX_DIGIT (10..15): no insert pulse, num and count unchanged, err←1;
    - finish event: ignored, no err.
  - FULL:
    - full=1;
    - insert event: ignored, err←1;
    - finish event: pulse finish, digit_count←0, go to COLLECT;
    - num keeps the fifth digit after finish (the game FSM samples num while evaluating).
- Priority and collisions:
  - same-cycle insert and finish events: the state-appropriate one is acted on, the other is handled per the rules above;
  - insert and finish are never both high in the same cycle.
- Reset (any cycle, including mid-debounce or mid-ticket):
  - num=0, insert=0, finish=0, digit_count=0, full=0, err=0, state COLLECT, debounce counters 0;
  - button synchronizer flops and debounced levels load 1 ("pressed"), so a button held through reset produces no event;
  - a released button debounces to 0 silently.
- digit_count never exceeds NUM_DIGITS and never wraps.

Test Plan:
1. After reset, release buttons. Set sw_num=5 and hold btn_insert high 20 cycles → exactly one insert pulse at edge k+6, num=5, digit_count=1, err=0.
2. Enter 5,0,9,6,7 with clean presses, then press finish → five insert pulses with num matching each digit, full=1 after the fifth, then one finish pulse, digit_count=0, full=0, num stays 7.
3. Toggle btn_insert high for 3 cycles, low for 2, repeatedly, over 30 cycles (bounce shorter than DEBOUNCE_CYCLES), then hold high → no pulse during the bounce, exactly one insert pulse after the stable hold.
4. Insert with sw_num=12 → no insert, err=1, digit_count unchanged. Next insert with sw_num=3 → insert pulse, num=3, err=0.
5. Press finish at digit_count=2 → no finish pulse. At digit_count=5, press insert → err=1, no pulse. Press finish → finish pulse.
6. Hold btn_insert high through reset assertion and release of reset → no insert event. Release then re-press → one insert. Assert reset at digit_count=3 → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/loteria_entrada.sv
// Input conditioning for the lottery game FSM: synchronizes and debounces the
// board buttons/switches and turns them into clean insert/finish strobes.
module loteria_entrada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS      = 5,
  parameter int unsigned MAX_DIGIT       = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_num,
  input  logic       btn_insert,
  input  logic       btn_finish,
  output logic [3:0] num,
  output logic       insert,
  output logic       finish,
  output logic [2:0] digit_count,
  output logic       full,
  output logic       err
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NB    = 2;
  localparam int unsigned BI    = 0;
  localparam int unsigned BF    = 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_e;

  logic [3:0]       sw_s1_q, sw_s2_q;
  logic [NB-1:0]    btn_s1_q, btn_s2_q;
  logic [NB-1:0]    deb_q, deb_d, deb_prev_q;
  logic [NB-1:0]    press_c;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  state_e     state_q, state_d;
  logic [3:0] num_q, num_d;
  logic       insert_q, insert_d;
  logic       finish_q, finish_d;
  logic [2:0] count_q, count_d;
  logic       full_q, full_d;
  logic       err_q, err_d;

  // Buttons reset to "pressed" so a button held through reset never makes an event
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
    end else begin
      sw_s1_q  <= sw_num;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= {btn_finish, btn_insert};
      btn_s2_q <= btn_s1_q;
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press_c = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_COLLECT;
      num_q    <= '0;
      insert_q <= 1'b0;
      finish_q <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      insert_q <= insert_d;
      finish_q <= finish_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  // Ticket sequencing; in FULL a colliding insert still flags err while finish is served
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    insert_d = 1'b0;
    finish_d = 1'b0;
    count_d  = count_q;
    err_d    = err_q;
    case (state_q)
      S_COLLECT: begin
        if (press_c[BI]) begin
          if (sw_s2_q <= 4'(MAX_DIGIT)) begin
            num_d    = sw_s2_q;
            insert_d = 1'b1;
            count_d  = count_q + 3'(1);
            err_d    = 1'b0;
            if (count_d == 3'(NUM_DIGITS)) state_d = S_FULL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (press_c[BI]) err_d = 1'b1;
        if (press_c[BF]) begin
          finish_d = 1'b1;
          count_d  = '0;
          state_d  = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    full_d = (state_d == S_FULL);
  end

  assign num         = num_q;
  assign insert      = insert_q;
  assign finish      = finish_q;
  assign digit_count = count_q;
  assign full        = full_q;
  assign err         = err_q;

endmodule

// File: tb/tb_loteria_entrada.sv
// Directed bench for loteria_entrada: latency, ticket sequencing, bounce
// rejection, invalid digits, over-entry and reset behaviour.
module tb_loteria_entrada;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_num = 4'd0;
  logic       btn_insert = 1'b0;
  logic       btn_finish = 1'b0;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic [2:0] digit_count;
  logic       full;
  logic       err;

  int tests = 0;
  int fails = 0;
  int ins_cnt = 0;
  int fin_cnt = 0;
  int both_cnt = 0;
  int base_i;
  int base_f;

  loteria_entrada dut (
    .clk         (clk),
    .reset       (reset),
    .sw_num      (sw_num),
    .btn_insert  (btn_insert),
    .btn_finish  (btn_finish),
    .num         (num),
    .insert      (insert),
    .finish      (finish),
    .digit_count (digit_count),
    .full        (full),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Strobe tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (insert) ins_cnt++;
    if (finish) fin_cnt++;
    if (insert && finish) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    btn_insert = 1'b0;
    btn_finish = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_ins(input logic [3:0] d);
    sw_num = d;
    btn_insert = 1'b1;
    repeat (12) tick();
    btn_insert = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_fin();
    btn_finish = 1'b1;
    repeat (12) tick();
    btn_finish = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_num", 8'(num), 8'd0);
    check("rst_insert", 8'(insert), 8'd0);
    check("rst_finish", 8'(finish), 8'd0);
    check("rst_count", 8'(digit_count), 8'd0);
    check("rst_full", 8'(full), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    reset = 1'b0;
    repeat (10) tick();
    check("rst_release_silent", 8'(ins_cnt + fin_cnt), 8'd0);

    // 1: exact latency of a long hold
    base_i = ins_cnt;
    sw_num = 4'd5;
    btn_insert = 1'b1;
    tick();
    repeat (5) tick();
    check("t1_pre_edge", 8'(insert), 8'd0);
    tick();
    check("t1_strobe", 8'(insert), 8'd1);
    check("t1_num", 8'(num), 8'd5);
    check("t1_count", 8'(digit_count), 8'd1);
    check("t1_err", 8'(err), 8'd0);
    tick();
    check("t1_strobe_low", 8'(insert), 8'd0);
    repeat (13) tick();
    btn_insert = 1'b0;
    repeat (10) tick();
    check("t1_one_pulse", 8'(ins_cnt - base_i), 8'd1);

    // 2: full ticket then finish
    do_reset();
    base_i = ins_cnt;
    base_f = fin_cnt;
    press_ins(4'd5);
    check("t2_num0", 8'(num), 8'd5);
    press_ins(4'd0);
    check("t2_num1", 8'(num), 8'd0);
    press_ins(4'd9);
    check("t2_num2", 8'(num), 8'd9);
    check("t2_full_mid", 8'(full), 8'd0);
    press_ins(4'd6);
    check("t2_num3", 8'(num), 8'd6);
    check("t2_count4", 8'(digit_count), 8'd4);
    press_ins(4'd7);
    check("t2_num4", 8'(num), 8'd7);
    check("t2_count5", 8'(digit_count), 8'd5);
    check("t2_full", 8'(full), 8'd1);
    check("t2_ins_pulses", 8'(ins_cnt - base_i), 8'd5);
    press_fin();
    check("t2_fin_pulses", 8'(fin_cnt - base_f), 8'd1);
    check("t2_count0", 8'(digit_count), 8'd0);
    check("t2_full_clr", 8'(full), 8'd0);
    check("t2_num_kept", 8'(num), 8'd7);
    check("t2_err", 8'(err), 8'd0);

    // 3: bounce shorter than the debounce window
    do_reset();
    base_i = ins_cnt;
    sw_num = 4'd4;
    for (int r = 0; r < 6; r++) begin
      btn_insert = 1'b1;
      repeat (3) tick();
      btn_insert = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
    check("t3_bounce_none", 8'(ins_cnt - base_i), 8'd0);
    btn_insert = 1'b1;
    repeat (12) tick();
    btn_insert = 1'b0;
    repeat (10) tick();
    check("t3_one_pulse", 8'(ins_cnt - base_i), 8'd1);
    check("t3_num", 8'(num), 8'd4);
    check("t3_count", 8'(digit_count), 8'd1);

    // 4: invalid digit then recovery
    do_reset();
    base_i = ins_cnt;
    press_ins(4'd12);
    check("t4_no_pulse", 8'(ins_cnt - base_i), 8'd0);
    check("t4_err", 8'(err), 8'd1);
    check("t4_count", 8'(digit_count), 8'd0);
    check("t4_num", 8'(num), 8'd0);
    press_ins(4'd3);
    check("t4_pulse", 8'(ins_cnt - base_i), 8'd1);
    check("t4_num3", 8'(num), 8'd3);
    check("t4_err_clr", 8'(err), 8'd0);
    check("t4_count1", 8'(digit_count), 8'd1);

    // 5: early finish ignored, over-entry flagged
    do_reset();
    press_ins(4'd1);
    press_ins(4'd2);
    base_f = fin_cnt;
    press_fin();
    check("t5_early_fin", 8'(fin_cnt - base_f), 8'd0);
    check("t5_early_err", 8'(err), 8'd0);
    check("t5_count2", 8'(digit_count), 8'd2);
    press_ins(4'd3);
    press_ins(4'd4);
    press_ins(4'd5);
    check("t5_full", 8'(full), 8'd1);
    base_i = ins_cnt;
    press_ins(4'd6);
    check("t5_over_nopulse", 8'(ins_cnt - base_i), 8'd0);
    check("t5_over_err", 8'(err), 8'd1);
    check("t5_over_num", 8'(num), 8'd5);
    check("t5_over_count", 8'(digit_count), 8'd5);
    press_fin();
    check("t5_fin", 8'(fin_cnt - base_f), 8'd1);
    check("t5_fin_count", 8'(digit_count), 8'd0);
    check("t5_fin_full", 8'(full), 8'd0);
    check("t5_err_sticky", 8'(err), 8'd1);

    // 6: button held through reset, then mid-ticket reset
    btn_insert = 1'b1;
    sw_num = 4'd8;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    base_i = ins_cnt;
    repeat (15) tick();
    check("t6_held_none", 8'(ins_cnt - base_i), 8'd0);
    btn_insert = 1'b0;
    repeat (10) tick();
    check("t6_release_none", 8'(ins_cnt - base_i), 8'd0);
    press_ins(4'd8);
    check("t6_repress", 8'(ins_cnt - base_i), 8'd1);
    check("t6_count1", 8'(digit_count), 8'd1);
    press_ins(4'd1);
    press_ins(4'd2);
    press_ins(4'd13);
    check("t6_count3", 8'(digit_count), 8'd3);
    check("t6_err_pre", 8'(err), 8'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_num", 8'(num), 8'd0);
    check("t6_rst_count", 8'(digit_count), 8'd0);
    check("t6_rst_full", 8'(full), 8'd0);
    check("t6_rst_err", 8'(err), 8'd0);
    check("t6_rst_insert", 8'(insert), 8'd0);
    check("t6_rst_finish", 8'(finish), 8'd0);
    reset = 1'b0;
    repeat (3) tick();

    check("never_both", 8'(both_cnt), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
